// File: rtl/mem_burst_ctrl_pkg.sv
// Shared types and default parameter values for the burst memory controller.
package mem_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER
  } ctrl_state_t;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } pktType_t;

  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_MEM_DEPTH   = 256;
  localparam int unsigned DEF_BURST_LEN   = 4;
  localparam int unsigned DEF_WAIT_STATES = 0;
  localparam logic [7:0]  DEF_PAGE_ID     = 8'h20;

endpackage

// File: rtl/mem_burst_ctrl_mem_array.sv
// Word storage: synchronous write, combinational read, no reset on the array.
module mem_array #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_burst_ctrl.sv
// Paged burst memory controller: address phase, optional wait states, then
// BURST_LEN read or write beats wrapping inside the aligned burst block.
module mem_burst_ctrl
  import mem_burst_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
  parameter logic [7:0]  PAGE_ID     = DEF_PAGE_ID
) (
  input  logic              clk,
  input  logic              resetH,
  input  logic              AddrValid,
  input  logic              rw,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              beat_valid,
  output logic              busy
);

  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned LB     = $clog2(BURST_LEN);
  localparam int unsigned CNT_W  = LB + 1;
  localparam int unsigned PAGE_W = DATA_W - IDX_W;

  localparam logic [IDX_W-1:0] WRAP_MASK = IDX_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [3:0]       LAST_WAIT = 4'(WAIT_STATES - 1);

  ctrl_state_t       state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  pktType_t          rw_q, rw_d;
  logic [IDX_W-1:0]  start_q, start_d;
  logic [IDX_W-1:0]  beat_idx;
  logic [DATA_W-1:0] rdata;
  logic              page_hit;
  logic              we;

  assign page_hit = (bus_in[DATA_W-1:IDX_W] == PAGE_W'(PAGE_ID));

  // Masked merge keeps the offset wrapping inside the burst block and also
  // covers BURST_LEN = 1, where the offset field has zero width.
  assign beat_idx = (start_q & ~WRAP_MASK) | ((start_q + IDX_W'(beat_q)) & WRAP_MASK);

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state_q <= IDLE;
      wait_q  <= '0;
      beat_q  <= '0;
      rw_q    <= WRITE;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      rw_q    <= rw_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    rw_d    = rw_q;
    start_d = start_q;
    case (state_q)
      IDLE: begin
        if (AddrValid && page_hit) begin
          rw_d    = pktType_t'(rw);
          start_d = bus_in[IDX_W-1:0];
          wait_d  = '0;
          beat_d  = '0;
          state_d = (WAIT_STATES == 0) ? XFER : WAIT;
        end
      end
      WAIT: begin
        if (wait_q == LAST_WAIT) begin
          wait_d  = '0;
          state_d = XFER;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      XFER: begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign beat_valid = (state_q == XFER);
  assign bus_oe     = beat_valid && (rw_q == READ);
  assign we         = beat_valid && (rw_q == WRITE);
  assign bus_out    = bus_oe ? rdata : '0;

  mem_array #(
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .addr (beat_idx),
    .wdata(bus_in),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl: default instance plus a
// WAIT_STATES=3 / BURST_LEN=8 instance.
module tb_mem_burst_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        av0, rw0, oe0, bv0, busy0;
  logic [15:0] bin0, bout0;
  logic        av1, rw1, oe1, bv1, busy1;
  logic [15:0] bin1, bout1;

  mem_burst_ctrl u0 (
    .clk(clk), .resetH(rst), .AddrValid(av0), .rw(rw0), .bus_in(bin0),
    .bus_out(bout0), .bus_oe(oe0), .beat_valid(bv0), .busy(busy0)
  );

  mem_burst_ctrl #(
    .WAIT_STATES(3),
    .BURST_LEN  (8)
  ) u1 (
    .clk(clk), .resetH(rst), .AddrValid(av1), .rw(rw1), .bus_in(bin1),
    .bus_out(bout1), .bus_oe(oe1), .beat_valid(bv1), .busy(busy1)
  );

  typedef struct {
    int          cyc;
    logic        oe;
    logic [15:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] m0 [256];
  logic [15:0] m1 [256];
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst) begin
      if (bv0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL sb0_unexpected_beat cyc=%0d oe=%b data=%h required no beat", cyc, oe0, bout0);
        end else begin
          e = q0.pop_front();
          if (cyc !== e.cyc || oe0 !== e.oe || bout0 !== e.data) begin
            errors++;
            $display("FAIL sb0_beat got cyc=%0d oe=%b data=%h required cyc=%0d oe=%b data=%h",
                     cyc, oe0, bout0, e.cyc, e.oe, e.data);
          end
        end
      end
      if (!oe0) begin
        checks++;
        if (bout0 !== 16'h0) begin
          errors++;
          $display("FAIL sb0_out_idle cyc=%0d got %h required 0000", cyc, bout0);
        end
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst) begin
      if (bv1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sb1_unexpected_beat cyc=%0d oe=%b data=%h required no beat", cyc, oe1, bout1);
        end else begin
          e = q1.pop_front();
          if (cyc !== e.cyc || oe1 !== e.oe || bout1 !== e.data) begin
            errors++;
            $display("FAIL sb1_beat got cyc=%0d oe=%b data=%h required cyc=%0d oe=%b data=%h",
                     cyc, oe1, bout1, e.cyc, e.oe, e.data);
          end
        end
      end
      if (!oe1) begin
        checks++;
        if (bout1 !== 16'h0) begin
          errors++;
          $display("FAIL sb1_out_idle cyc=%0d got %h required 0000", cyc, bout1);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge following the last beat.
  task automatic burst0(input logic r, input logic [15:0] addr, input logic [63:0] dat,
                        input int pulse_beat);
    logic [7:0] idx;
    exp_t       e;
    av0 = 1'b1; rw0 = r; bin0 = addr;
    for (int k = 0; k < 4; k++) begin
      idx   = {addr[7:2], 2'(addr[1:0] + k)};
      e.cyc = cyc + 1 + k;
      e.oe  = r;
      if (r) e.data = m0[idx];
      else begin
        e.data  = 16'h0;
        m0[idx] = dat[k*16 +: 16];
      end
      q0.push_back(e);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      if (k == pulse_beat) begin
        av0 = 1'b1; rw0 = 1'b0; bin0 = 16'h2000;
      end else begin
        av0 = 1'b0; rw0 = 1'b0; bin0 = r ? 16'h0 : dat[k*16 +: 16];
      end
      checks++;
      if (busy0 !== 1'b1 || bv0 !== 1'b1) begin
        errors++;
        $display("FAIL burst0_beat%0d busy=%b beat_valid=%b required 1 1", k, busy0, bv0);
      end
      @(posedge clk); #1;
    end
    av0 = 1'b0; bin0 = 16'h0;
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL burst0_busy_end got %b required 0", busy0);
    end
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL sb0_missing_beats got %0d pending required 0", q0.size());
    end
  endtask

  task automatic burst1(input logic r, input logic [15:0] addr, input logic [127:0] dat);
    logic [7:0] idx;
    exp_t       e;
    av1 = 1'b1; rw1 = r; bin1 = addr;
    for (int k = 0; k < 8; k++) begin
      idx   = {addr[7:3], 3'(addr[2:0] + k)};
      e.cyc = cyc + 4 + k;
      e.oe  = r;
      if (r) e.data = m1[idx];
      else begin
        e.data  = 16'h0;
        m1[idx] = dat[k*16 +: 16];
      end
      q1.push_back(e);
    end
    @(posedge clk); #1;
    av1 = 1'b0; rw1 = 1'b0; bin1 = 16'h0;
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (busy1 !== 1'b1 || bv1 !== 1'b0) begin
        errors++;
        $display("FAIL burst1_wait%0d busy=%b beat_valid=%b required 1 0", w, busy1, bv1);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 8; k++) begin
      bin1 = r ? 16'h0 : dat[k*16 +: 16];
      checks++;
      if (busy1 !== 1'b1 || bv1 !== 1'b1) begin
        errors++;
        $display("FAIL burst1_beat%0d busy=%b beat_valid=%b required 1 1", k, busy1, bv1);
      end
      @(posedge clk); #1;
    end
    bin1 = 16'h0;
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL burst1_busy_end got %b required 0", busy1);
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL sb1_missing_beats got %0d pending required 0", q1.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy0, bv0, oe0, bout0, busy1, bv1, oe1, bout1} !== 38'h0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b bv=%b oe=%b out=%h / busy=%b bv=%b oe=%b out=%h required all 0",
               busy0, bv0, oe0, bout0, busy1, bv1, oe1, bout1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    burst0(1'b0, 16'h2004, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, -1);
  endtask

  task automatic test_read_wrap();
    burst0(1'b1, 16'h2006, 64'h0, -1);
  endtask

  task automatic test_page_miss();
    av0 = 1'b1; rw0 = 1'b0; bin0 = 16'h3004;
    @(posedge clk); #1;
    av0 = 1'b0; bin0 = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy0 !== 1'b0) begin
        errors++;
        $display("FAIL page_miss_busy cycle %0d got %b required 0", i, busy0);
      end
      @(posedge clk); #1;
    end
    bin0 = 16'h0;
    burst0(1'b1, 16'h2004, 64'h0, -1);
  endtask

  task automatic test_ignore_addr();
    burst0(1'b1, 16'h2004, 64'h0, 2);
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_addr_busy got %b required 0", busy0);
    end
  endtask

  task automatic test_back_to_back();
    burst0(1'b0, 16'h2008, {16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0}, -1);
    burst0(1'b1, 16'h2008, 64'h0, -1);
  endtask

  task automatic test_reset_abort();
    exp_t e;
    av0 = 1'b1; rw0 = 1'b0; bin0 = 16'h2008;
    e.cyc = cyc + 1; e.oe = 1'b0; e.data = 16'h0;
    q0.push_back(e);
    m0[8'h08] = 16'h00B0;
    @(posedge clk); #1;
    av0 = 1'b0; bin0 = 16'h00B0;
    @(posedge clk); #1;
    bin0 = 16'h00B1;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy0, bv0, oe0, bout0} !== 19'h0) begin
      errors++;
      $display("FAIL reset_abort_outputs got busy=%b bv=%b oe=%b out=%h required all 0",
               busy0, bv0, oe0, bout0);
    end
    @(posedge clk); #1;
    bin0 = 16'h00B2;
    rst = 1'b0;
    @(posedge clk); #1;
    bin0 = 16'h0;
    checks++;
    if (busy0 !== 1'b0 || q0.size() != 0) begin
      errors++;
      $display("FAIL reset_abort_idle got busy=%b pending=%0d required 0 0", busy0, q0.size());
    end
    burst0(1'b1, 16'h2008, 64'h0, -1);
  endtask

  task automatic test_wait_states();
    logic [127:0] d;
    for (int k = 0; k < 8; k++) d[k*16 +: 16] = 16'h1000 + 16'(k * 16'h0111);
    burst1(1'b0, 16'h2010, d);
    burst1(1'b1, 16'h2010, 128'h0);
    burst1(1'b1, 16'h2013, 128'h0);
  endtask

  initial begin
    rst = 1'b1;
    av0 = 1'b0; rw0 = 1'b0; bin0 = 16'h0;
    av1 = 1'b0; rw1 = 1'b0; bin1 = 16'h0;
    test_reset();
    test_write();
    test_read_wrap();
    test_page_miss();
    test_ignore_addr();
    test_back_to_back();
    test_reset_abort();
    test_wait_states();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_burst_ctrl.md
MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter DATA_W, default 16: data and address bus width in bits.
REQ-003 Parameter MEM_DEPTH, default 256: words stored; power of two; IDX_W = log2(MEM_DEPTH).
REQ-004 Parameter BURST_LEN, default 4: beats per transaction; power of two, 1..MEM_DEPTH.
REQ-005 Parameter WAIT_STATES, default 0: idle cycles between address phase and first beat, 0..15.
REQ-006 Parameter PAGE_ID, default 8'h20: value that bus_in[DATA_W-1:IDX_W] must match for the block to select itself.
REQ-007 Port clk, input, 1: rising-edge clock.
REQ-008 Port resetH, input, 1: asynchronous active-high reset.
REQ-009 Port AddrValid, input, 1: address phase strobe.
REQ-010 Port rw, input, 1: transaction type sampled with AddrValid; 1 = READ, 0 = WRITE.
REQ-011 Port bus_in, input, DATA_W: address in the address phase, write data in write beats.
REQ-012 Port bus_out, output, DATA_W: read data.
REQ-013 Port bus_oe, output, 1: high exactly during read beats.
REQ-014 Port beat_valid, output, 1: high on every data beat, read or write.
REQ-015 Port busy, output, 1: high from the cycle after an accepted address phase through the last beat.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, XFER.
- IDLE to WAIT on AddrValid with a page hit when WAIT_STATES > 0.
- IDLE to XFER on AddrValid with a page hit when WAIT_STATES = 0.
- WAIT to XFER after WAIT_STATES cycles.
- XFER to IDLE after BURST_LEN beats.
REQ-017 In IDLE with AddrValid=1, the block SHALL register rw and the start index bus_in[IDX_W-1:0]; on a page miss it SHALL stay in IDLE and register nothing.
REQ-018 Beat k SHALL access index {start[IDX_W-1:log2(BURST_LEN)], (start[log2(BURST_LEN)-1:0]+k) mod BURST_LEN}; this wraps within the aligned burst block and never carries into the upper bits.
REQ-019 Write beat: mem[index] SHALL take bus_in on the clock edge that ends the beat; bus_oe=0.
REQ-020 Read beat: bus_out SHALL equal mem[index] combinationally in the same cycle; bus_oe=1.
REQ-021 Latency: with the address phase in cycle 0, beat 0 SHALL occur in cycle 1+WAIT_STATES and the last beat in cycle WAIT_STATES+BURST_LEN.
REQ-022 AddrValid SHALL be ignored while busy=1; a new address phase is accepted in the cycle after the last beat.
REQ-023 bus_out SHALL be 0 whenever bus_oe=0.
REQ-024 The beat counter SHALL be log2(BURST_LEN)+1 bits wide and the wait counter 4 bits wide; neither SHALL wrap unintentionally.

Reset
REQ-025 On resetH=1, regardless of clock, the FSM SHALL go to IDLE and busy, beat_valid, bus_oe and bus_out SHALL go to 0, with counters and latched rw/index cleared.
REQ-026 Reset asserted mid-burst SHALL abort the burst; words already written SHALL keep their values; the memory array SHALL NOT be reset.

Structure
REQ-027 The shared definitions package SHALL hold the ctrl_state_t enum (IDLE, WAIT, XFER) and default parameter constants; pktType_t SHALL be reused for rw.
REQ-028 Storage SHALL be a sub-module, mem_array: parametrised by DATA_W and MEM_DEPTH, with synchronous write and combinational read.

Verification
REQ-029 Defaults: write burst at 16'h2004 with data A0,A1,A2,A3 -> indices 04..07 = A0..A3; beat_valid high cycles 1-4; bus_oe stays 0.
REQ-030 Read at 16'h2006 after REQ-029 -> bus_out = A2,A3,A0,A1 in cycles 1-4 with bus_oe=1 (wrap).
REQ-031 Address 16'h3004 with AddrValid -> busy stays 0; memory unchanged.
REQ-032 WAIT_STATES=3, BURST_LEN=8, read at 16'h2010 -> first beat in cycle 4, last in cycle 11.
REQ-033 AddrValid pulsed during beat 2 -> ignored; burst completes normally.
REQ-034 resetH asserted during beat 1 of a write -> outputs go to 0 immediately; beat 0 word retained; beats 2-3 not written.
